// File: rtl/window3x3_gen.sv
// ---------------------------------------------------------------------------
// window3x3_gen
//
// Builds the 3x3 RGB444 neighbourhood bus for the video filter bank from a
// single raster-order pixel stream. Two line buffers hold the previous two
// lines. A 3x3 register window slides one column per stream advance. Each
// window is emitted centred on its pixel, and out-of-image neighbours are
// forced to black.
//
// Stream model: every accepted pixel is one "advance". After the last pixel
// of a frame, the block injects IMG_WIDTH+1 virtual zero advances (FLUSH) so
// that the bottom line and the last pixel get their windows. The window for
// centre c is complete on advance c+IMG_WIDTH+1. That window is presented
// two clock edges later: one edge for the RAM read register and one edge for
// the output register.
//
// Ports:
//   clk        : clock
//   reset      : asynchronous, active-high reset
//   pix_in     : RGB444 pixel {R[11:8], G[7:4], B[3:0]}
//   pix_valid  : pix_in is valid this cycle
//   sof        : with pix_valid, marks pixel (0,0) of a frame
//   pix_ready  : a pixel is accepted when pix_valid && pix_ready
//   color_data : {centre, left, right, up, down,
//                 upleft, upright, downleft, downright}, 12 bits each
//   data_valid : one-cycle pulse per window
//   out_x      : centre column (zero-extended)
//   out_y      : centre row (zero-extended)
//   eof        : high with data_valid for the last window of the frame
// ---------------------------------------------------------------------------
module window3x3_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [11:0]  pix_in,
    input  logic         pix_valid,
    input  logic         sof,
    output logic         pix_ready,
    output logic [107:0] color_data,
    output logic         data_valid,
    output logic [9:0]   out_x,
    output logic [9:0]   out_y,
    output logic         eof
);

    localparam int AW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int FW = $clog2(IMG_WIDTH + 2);

    localparam logic [AW-1:0] X_LAST     = AW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] FILL_DONE  = FW'(IMG_WIDTH + 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t state, state_next;

    // Stream-side counters: position of the element being advanced, and
    // the centre of the next window due out.
    logic [AW-1:0] adv_x;
    logic [YW-1:0] adv_y;
    logic [FW-1:0] fill_cnt;
    logic [FW-1:0] flush_cnt;
    logic [AW-1:0] cen_x;
    logic [YW-1:0] cen_y;

    logic          accept;
    logic          adv;
    logic          start;
    logic          abort;
    logic          emit;
    logic [11:0]   adv_pix;
    logic [AW-1:0] adv_col;

    // Line buffers: lb0 holds the line above the incoming element, and
    // lb1 holds the line above that.
    logic [11:0] lb0 [IMG_WIDTH];
    logic [11:0] lb1 [IMG_WIDTH];
    logic [11:0] rd0;
    logic [11:0] rd1;

    // Stage 1: the advance has been captured and the RAM read is in flight.
    logic          s1_adv;
    logic          s1_emit;
    logic [AW-1:0] s1_col;
    logic [11:0]   s1_pix;
    logic [AW-1:0] s1_cx;
    logic [YW-1:0] s1_cy;
    logic          s1_eof;

    // Stage 2: the window is shifted and ready to mask.
    // win[row][col]: row 0 is the oldest line, and col 2 is the newest column.
    logic [2:0][2:0][11:0] win;
    logic                  s2_emit;
    logic [AW-1:0]         s2_cx;
    logic [YW-1:0]         s2_cy;
    logic                  s2_eof;

    logic [107:0] win_masked;

    assign accept = pix_valid && pix_ready;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: state-holding logic uses non-blocking assignments so that every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pix_ready <= 1'b0;
        end else begin
            state     <= state_next;
            pix_ready <= (state_next != S_FLUSH);
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and advance control
    // -----------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so
    // paths that do not assign it cannot infer a latch.
    always_comb begin
        state_next = state;
        adv        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        adv_pix    = 12'h000;
        case (state)
            S_IDLE: begin
                // Pixels without sof are accepted and dropped.
                if (accept && sof) begin
                    adv        = 1'b1;
                    start      = 1'b1;
                    adv_pix    = pix_in;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    adv     = 1'b1;
                    adv_pix = pix_in;
                    if (sof) begin
                        // Restart on a new frame. Everything in flight
                        // from the old frame is discarded.
                        start = 1'b1;
                        abort = 1'b1;
                    end else if (adv_x == X_LAST && adv_y == Y_LAST) begin
                        state_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Virtual black pixels push the last windows out.
                adv = 1'b1;
                if (flush_cnt == FLUSH_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The sof pixel always lands in column 0, whatever adv_x held before.
    assign adv_col = start ? '0 : adv_x;
    assign emit    = adv && !start && (fill_cnt == FILL_DONE);

    // -----------------------------------------------------------------------
    // Stream position, fill and centre counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adv_x     <= '0;
            adv_y     <= '0;
            fill_cnt  <= '0;
            flush_cnt <= '0;
            cen_x     <= '0;
            cen_y     <= '0;
        end else begin
            if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt + FW'(1);
            end else begin
                flush_cnt <= '0;
            end

            if (adv) begin
                if (start) begin
                    adv_x    <= AW'(1);
                    adv_y    <= '0;
                    fill_cnt <= FW'(1);
                    cen_x    <= '0;
                    cen_y    <= '0;
                end else begin
                    if (adv_x == X_LAST) begin
                        adv_x <= '0;
                        adv_y <= (adv_y == Y_LAST) ? '0 : adv_y + YW'(1);
                    end else begin
                        adv_x <= adv_x + AW'(1);
                    end

                    // The first IMG_WIDTH+1 advances only fill the window.
                    if (fill_cnt != FILL_DONE) begin
                        fill_cnt <= fill_cnt + FW'(1);
                    end

                    if (emit) begin
                        if (cen_x == X_LAST) begin
                            cen_x <= '0;
                            cen_y <= (cen_y == Y_LAST) ? '0 : cen_y + YW'(1);
                        end else begin
                            cen_x <= cen_x + AW'(1);
                        end
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Line buffer RAMs
    // -----------------------------------------------------------------------
    // NOTE: the RAMs and their read registers have no reset. Stale contents
    // only reach border positions, and the output mask blanks those.
    always_ff @(posedge clk) begin
        if (adv) begin
            rd0          <= lb0[adv_col];
            rd1          <= lb1[adv_col];
            lb0[adv_col] <= adv_pix;
        end
        // The line leaving lb0 moves down into lb1 one cycle later, taken
        // from the registered read.
        if (s1_adv) begin
            lb1[s1_col] <= rd0;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: capture the advance alongside the RAM read
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_adv  <= 1'b0;
            s1_emit <= 1'b0;
            s1_col  <= '0;
            s1_pix  <= '0;
            s1_cx   <= '0;
            s1_cy   <= '0;
            s1_eof  <= 1'b0;
        end else begin
            s1_adv  <= adv;
            s1_emit <= emit;
            if (adv) begin
                s1_col <= adv_col;
                s1_pix <= adv_pix;
                s1_cx  <= cen_x;
                s1_cy  <= cen_y;
                s1_eof <= (cen_x == X_LAST) && (cen_y == Y_LAST);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: slide the 3x3 window one column per advance
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win     <= '0;
            s2_emit <= 1'b0;
            s2_cx   <= '0;
            s2_cy   <= '0;
            s2_eof  <= 1'b0;
        end else begin
            if (s1_adv) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= rd1;
                win[1][2] <= rd0;
                win[2][2] <= s1_pix;
            end
            s2_emit <= s1_emit && !abort;
            s2_cx   <= s1_cx;
            s2_cy   <= s1_cy;
            s2_eof  <= s1_eof;
        end
    end

    // -----------------------------------------------------------------------
    // Border mask: win[1][1] is the centre, and neighbours outside the image
    // (including those that wrap across lines) become black.
    // -----------------------------------------------------------------------
    always_comb begin
        logic lz, rz, uz, dz;
        lz = (s2_cx == '0);
        rz = (s2_cx == X_LAST);
        uz = (s2_cy == '0);
        dz = (s2_cy == Y_LAST);
        win_masked = {
            win[1][1],
            lz         ? 12'h000 : win[1][0],
            rz         ? 12'h000 : win[1][2],
            uz         ? 12'h000 : win[0][1],
            dz         ? 12'h000 : win[2][1],
            (lz || uz) ? 12'h000 : win[0][0],
            (rz || uz) ? 12'h000 : win[0][2],
            (lz || dz) ? 12'h000 : win[2][0],
            (rz || dz) ? 12'h000 : win[2][2]
        };
    end

    // -----------------------------------------------------------------------
    // Output register: color_data and coordinates hold between pulses.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_data <= '0;
            data_valid <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            eof        <= 1'b0;
        end else begin
            data_valid <= s2_emit && !abort;
            eof        <= s2_emit && !abort && s2_eof;
            if (s2_emit && !abort) begin
                color_data <= win_masked;
                out_x      <= 10'(s2_cx);
                out_y      <= 10'(s2_cy);
            end
        end
    end

endmodule

// File: doc/window3x3_gen.md
# window3x3_gen

- Produces the 108-bit 3×3 RGB444 neighbourhood bus consumed by every filter block in the video effects chain.
- Accepts one 12-bit raster-order pixel stream and buffers two full lines in internal RAM. For each pixel it emits the pixel (as centre) plus its eight neighbours, packed in the fixed `color_data` layout. Neighbours outside the image are forced to black.
- Sits between the frame source (camera or VGA frame buffer reader) and the selectable filter bank.

## Interface
- `IMG_WIDTH`, default 640: pixels per line. Must be ≥2.
- `IMG_HEIGHT`, default 480: lines per frame. Must be ≥2.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset, asynchronous, active-high.
- `pix_in` input, 12 bits: RGB444 pixel, {R[11:8], G[7:4], B[3:0]}.
- `pix_valid` input, 1 bit: `pix_in` is valid this cycle.
- `sof` input, 1 bit: qualified by `pix_valid`. Marks pixel (0,0) of a frame.
- `pix_ready` output, 1 bit: the block accepts a pixel this cycle when `pix_valid && pix_ready`.
- `color_data` output, 108 bits, packed as:
  - [107:96] centre, [95:84] left, [83:72] right, [71:60] up, [59:48] down
  - [47:36] upleft, [35:24] upright, [23:12] downleft, [11:0] downright
- `data_valid` output, 1 bit: `color_data`, `out_x`, `out_y` and `eof` are valid. One-cycle pulse per window.
- `out_x` output, 10 bits: centre column.
- `out_y` output, 10 bits: centre row.
- `eof` output, 1 bit: high together with `data_valid` for window (W-1, H-1).

## Operation
- W = `IMG_WIDTH`, H = `IMG_HEIGHT`. Stream index n = y·W + x.
- Storage: two line buffers of W×12 bits each, plus a 3×3 register window that shifts one column per stream advance.
- FSM states:
  - IDLE: `pix_ready` = 1. Pixels without `sof` are accepted and discarded. An accepted pixel with `sof` becomes n = 0 and moves the FSM to RUN.
  - RUN: `pix_ready` = 1. Each accepted pixel advances the stream by one. Accepting n = W·H−1 moves the FSM to FLUSH.
  - FLUSH: `pix_ready` = 0. The FSM injects W+1 virtual zero pixels, one per cycle, then returns to IDLE.
- Window for centre index c is complete on the advance of stream element c+W+1, real or virtual. Advances 0..W are fill only and produce no output.
- Exactly W·H windows per frame, in raster order of the centre.
- Border rule: any neighbour with x±1 outside [0, W−1] or y±1 outside [0, H−1] is 12'h000. This includes neighbours that would otherwise wrap onto the previous or next line. The centre is never zeroed.
- `sof` accepted in RUN: the current frame is aborted. Windows not yet presented are suppressed, including those in the output pipeline. The sof pixel becomes n = 0 of a new frame and the FSM stays in RUN.
- `sof` is ignored while in FLUSH because `pix_ready` = 0.
- Pixel data is passed through unmodified. No arithmetic is done on colour values.
- Counters: x wraps W−1→0 and increments y; y is never above H−1. `out_x`/`out_y` are zero-extended.

## Timing
- Reset values: `pix_ready` = 0 while `reset` is high, then 1 (IDLE). `color_data` = 0, `data_valid` = 0, `out_x` = 0, `out_y` = 0, `eof` = 0. Line buffer contents are don't-care because the border rule masks them.
- Latency: `data_valid` for centre c rises at the second rising edge after the edge that performs advance c+W+1. This is a fixed 2 cycles and covers one registered RAM read and one output register.
- All outputs are registered. `color_data` holds its value while `data_valid` = 0.
- Gaps in `pix_valid` stall the stream with no loss. Window outputs are spaced exactly like the corresponding advances.
- FLUSH lasts exactly W+1 cycles. The last `eof` pulse occurs 2 cycles after the final flush advance.
- Back-to-back frames: a new `sof` is accepted in the first cycle of IDLE. No `data_valid` of the new frame appears before the previous frame's `eof`.
- Reset mid-frame: all outputs are at reset values immediately (asynchronous). The FSM goes to IDLE and no stale window is emitted afterwards.

## Test plan
- Stimulus for the frame tests: W=4, H=3, pixel (x,y) = 12'h010·y + x + 1, streamed continuously.
- Basic frame with stimulus above:
  - Exactly 12 `data_valid` pulses.
  - Window (1,1): centre 0x012, left 0x011, right 0x013, up 0x002, down 0x022, upleft 0x001, upright 0x003, downleft 0x021, downright 0x023.
- Borders, same frame:
  - Window (0,0): centre 0x001, right 0x002, down 0x011, downright 0x012, all other fields 0.
  - Window (3,2): centre 0x024, left 0x023, up 0x014, upleft 0x013, all other fields 0, `eof` = 1.
- Flush and stall:
  - `pix_ready` low for exactly 5 cycles after accepting pixel 11.
  - Holding `pix_valid` high during those 5 cycles loses no data and accepts nothing.
  - Random `pix_valid` gaps produce window values identical to the continuous run.
- `sof` abort: send 6 pixels, then `sof` with a fresh frame.
  - No window of the aborted frame appears after the abort.
  - The new frame produces all 12 correct windows.
- Reset mid-frame: assert `reset` during the output of window (2,1).
  - Outputs are 0 in the same cycle.
  - After release, pixels without `sof` are ignored.
  - A full frame then completes correctly.
- IDLE discard: 3 pixels without `sof`, then a frame.
  - No `data_valid` from the 3 discarded pixels.
  - The frame output matches the basic frame test.
